alu_scheduler: RTL

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_ctrl_pkg.sv | 37 +++
 rtl/rr_arbiter_2.sv | 30 +++
 rtl/alu_scheduler.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU scheduler: op codes, per-op issue latency and FSM states.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_NOT  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;

  localparam int LAT_BASE = 1;
  localparam int LAT_MUL  = 2;
  localparam int LAT_DIV  = 4;
  localparam int LAT_MAX  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The counter holds cycles remaining after the current one, so it loads L-1.
  function automatic logic [1:0] lat_load(input logic [3:0] op);
    case (op)
      OP_MUL:  return 2'(LAT_MUL - 1);
      OP_DIV:  return 2'(LAT_DIV - 1);
      default: return 2'(LAT_BASE - 1);
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and starts out favouring req[0].
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external ALU between two requesters: arbitrates, issues for the op latency, then holds the response.
module alu_scheduler
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req1_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic       rsp_err
);

  state_t     state, next_state;
  logic [1:0] grant;
  logic       idle, accept;
  logic [3:0] acc_a, acc_b, acc_op;
  logic       acc_illegal, acc_divz;
  logic [3:0] op_a, op_b, op_code;
  logic [1:0] lat_cnt;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  assign idle       = (state == ST_IDLE) && !reset;
  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign acc_a       = grant[1] ? req1_a  : req0_a;
  assign acc_b       = grant[1] ? req1_b  : req0_b;
  assign acc_op      = grant[1] ? req1_op : req0_op;
  assign acc_illegal = acc_op > OP_DIV;
  assign acc_divz    = (acc_op == OP_DIV) && (acc_b == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Errors short-circuit straight to RESP so the ALU never sees the bad op.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = (acc_illegal || acc_divz) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (lat_cnt == 2'd0) next_state = ST_RESP;
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a       <= 4'd0;
      op_b       <= 4'd0;
      op_code    <= 4'd0;
      lat_cnt    <= 2'd0;
      rsp_id     <= 1'b0;
      rsp_result <= 4'd0;
      rsp_err    <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        op_a    <= acc_a;
        op_b    <= acc_b;
        op_code <= acc_op;
        lat_cnt <= lat_load(acc_op);
        rsp_id  <= grant[1];
        rsp_err <= acc_illegal || acc_divz;
        if (acc_illegal)   rsp_result <= 4'h0;
        else if (acc_divz) rsp_result <= 4'hF;
      end
    end else if (state == ST_BUSY) begin
      if (lat_cnt == 2'd0) rsp_result <= alu_result;
      else                 lat_cnt    <= lat_cnt - 2'd1;
    end
  end

  assign alu_a     = (state == ST_BUSY) ? op_a    : 4'd0;
  assign alu_b     = (state == ST_BUSY) ? op_b    : 4'd0;
  assign alu_op    = (state == ST_BUSY) ? op_code : 4'd0;
  assign rsp_valid = (state == ST_RESP);

endmodule
